// File: rtl/onehot_span_decoder_pkg.sv
// Shared entry type and the span/classification rule for the one-hot span decoder.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
//
// Contents:
//   IDX_MAX_W  widest bit index the entry type can carry (WIDTH up to 2**16)
//   entry_t    decoded entry: left_idx, right_idx, span, zero, err
//   classify() applies the classification priority to two decoded words
package onehot_span_pkg;

  localparam int IDX_MAX_W = 16;

  typedef struct packed {
    logic [IDX_MAX_W-1:0] left_idx;
    logic [IDX_MAX_W-1:0] right_idx;
    logic [IDX_MAX_W:0]   span;
    logic                 zero;
    logic                 err;
  } entry_t;

  // Checks run in priority order. A malformed word wins over everything, so a
  // multi-hot word paired with a zero word still reports err rather than zero.
  function automatic entry_t classify(
    input logic [IDX_MAX_W-1:0] l_idx,
    input logic [IDX_MAX_W-1:0] r_idx,
    input logic                 l_zero,
    input logic                 r_zero,
    input logic                 l_multi,
    input logic                 r_multi
  );
    entry_t e;
    e = '0;
    if (l_multi || r_multi) begin
      e.err = 1'b1;
    end else if (l_zero && r_zero) begin
      e.zero = 1'b1;
    end else if (l_zero || r_zero) begin
      e.err = 1'b1;
    end else if (l_idx < r_idx) begin
      // Inverted pair: keep the decoded indices for debug, but no span.
      e.err       = 1'b1;
      e.left_idx  = l_idx;
      e.right_idx = r_idx;
    end else begin
      e.left_idx  = l_idx;
      e.right_idx = r_idx;
      e.span      = {1'b0, l_idx} - {1'b0, r_idx} + (IDX_MAX_W + 1)'(1);
    end
    return e;
  endfunction

endpackage

// File: rtl/onehot_span_decoder_if.sv
// Bundles the encoder-side input words and the consumer-side valid/ready result bus.
// Latency: none (wiring only).
// Backpressure: ready_i from the consumer; the encoder side has no ready.
//
// Signals (named from the decoder's point of view):
//   data_left_i/data_right_i/data_val_i   one-hot words from the encoder
//   left_idx_o/right_idx_o/span_o/zero_o/err_o/valid_o/ready_i   FIFO head
//   level_o/overflow_o/drop_cnt_o         FIFO status and drop accounting
// Modports: slave = decoder, master = encoder/consumer side.
interface onehot_span_decoder_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] data_left_i;
  logic [WIDTH-1:0] data_right_i;
  logic             data_val_i;
  logic [IDX_W-1:0] left_idx_o;
  logic [IDX_W-1:0] right_idx_o;
  logic [IDX_W:0]   span_o;
  logic             zero_o;
  logic             err_o;
  logic             valid_o;
  logic             ready_i;
  logic [LVL_W-1:0] level_o;
  logic             overflow_o;
  logic [CNT_W-1:0] drop_cnt_o;

  modport slave (
    input  data_left_i, data_right_i, data_val_i, ready_i,
    output left_idx_o, right_idx_o, span_o, zero_o, err_o, valid_o,
           level_o, overflow_o, drop_cnt_o
  );

  modport master (
    output data_left_i, data_right_i, data_val_i, ready_i,
    input  left_idx_o, right_idx_o, span_o, zero_o, err_o, valid_o,
           level_o, overflow_o, drop_cnt_o
  );

endinterface

// File: rtl/onehot_span_decoder_onehot_to_index.sv
// Converts one word to a binary bit index and flags zero / multi-hot words.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   i_word   input word, expected one-hot
//   o_idx    OR of the positions of all set bits (exact only when one-hot)
//   o_zero   no bit set
//   o_multi  more than one bit set
module onehot_to_index #(
  parameter  int WIDTH = 16,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_word,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_zero,
  output logic             o_multi
);

  logic w_seen;

  // Each index bit is the OR of every word bit whose position has that bit
  // set. The running "seen" term flags a second set bit in the same pass.
  always_comb begin
    o_idx   = '0;
    o_multi = 1'b0;
    w_seen  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_word[i]) begin
        o_idx = o_idx | IDX_W'(i);
      end
      o_multi = o_multi | (w_seen & i_word[i]);
      w_seen  = w_seen | i_word[i];
    end
  end

  assign o_zero = ~|i_word;

endmodule

// File: rtl/onehot_span_decoder.sv
// Decodes encoder left/right one-hot words into indices + span and queues results.
// Latency: 2 cycles from data_val_i to valid_o (stage-1 register, then FIFO push).
// Backpressure: ready_i stalls the FIFO head; words arriving while full are dropped and counted.
//
// Ports:
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   bus (slave)      input words, FIFO head (valid/ready), level, overflow, drop count
module onehot_span_decoder
  import onehot_span_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  onehot_span_decoder_if.slave bus
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;

  // Storage only keeps the bits this WIDTH needs.
  typedef struct packed {
    logic [IDX_W-1:0] left_idx;
    logic [IDX_W-1:0] right_idx;
    logic [IDX_W:0]   span;
    logic             zero;
    logic             err;
  } slot_t;

  // ---------------------------------------------------------------- decode
  logic [IDX_W-1:0] w_left_idx;
  logic [IDX_W-1:0] w_right_idx;
  logic             w_left_zero;
  logic             w_right_zero;
  logic             w_left_multi;
  logic             w_right_multi;
  entry_t           w_cls;
  slot_t            w_slot;
  logic             w_unused_cls;

  onehot_to_index #(.WIDTH(WIDTH)) u_left (
    .i_word  (bus.data_left_i),
    .o_idx   (w_left_idx),
    .o_zero  (w_left_zero),
    .o_multi (w_left_multi)
  );

  onehot_to_index #(.WIDTH(WIDTH)) u_right (
    .i_word  (bus.data_right_i),
    .o_idx   (w_right_idx),
    .o_zero  (w_right_zero),
    .o_multi (w_right_multi)
  );

  assign w_cls = classify(IDX_MAX_W'(w_left_idx), IDX_MAX_W'(w_right_idx),
                          w_left_zero, w_right_zero, w_left_multi, w_right_multi);

  // The span never exceeds WIDTH, so narrowing to IDX_W+1 bits is lossless.
  assign w_slot = '{
    left_idx:  w_cls.left_idx[IDX_W-1:0],
    right_idx: w_cls.right_idx[IDX_W-1:0],
    span:      w_cls.span[IDX_W:0],
    zero:      w_cls.zero,
    err:       w_cls.err
  };

  // Upper entry bits are always zero for this WIDTH.
  assign w_unused_cls = ^w_cls;

  // --------------------------------------------------------------- stage 1
  logic  r_s1_vld;
  slot_t r_s1_slot;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_s1_vld <= 1'b0;
    end else begin
      r_s1_vld <= bus.data_val_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (bus.data_val_i) begin
      r_s1_slot <= w_slot;
    end
  end

  // ------------------------------------------------------------------ FIFO
  slot_t            r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic             r_overflow;
  logic [CNT_W-1:0] r_drop_cnt;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  slot_t            w_head;

  // Pointers carry one extra wrap bit: equal means empty, equal index with
  // differing wrap bit means full.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign w_pop   = ~w_empty & bus.ready_i;
  // A pop on the same edge frees the slot, so a full FIFO still takes the push.
  assign w_push  = r_s1_vld & (~w_full | w_pop);
  assign w_drop  = r_s1_vld & w_full & ~w_pop;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1) begin
          r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
      end
    end
  end

  // When full with a pop, the write lands in the slot being read this cycle;
  // the head is sampled before the edge so the outgoing entry is unaffected.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= r_s1_slot;
    end
  end

  // Gating on empty makes every output zero straight out of reset, since the
  // storage array itself is not reset.
  assign w_head = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];

  // --------------------------------------------------------------- outputs
  assign bus.left_idx_o  = w_head.left_idx;
  assign bus.right_idx_o = w_head.right_idx;
  assign bus.span_o      = w_head.span;
  assign bus.zero_o      = w_head.zero;
  assign bus.err_o       = w_head.err;
  assign bus.valid_o     = ~w_empty;
  assign bus.level_o     = r_wptr - r_rptr;
  assign bus.overflow_o  = r_overflow;
  assign bus.drop_cnt_o  = r_drop_cnt;

endmodule

// File: doc/onehot_span_decoder.md
Name: onehot_span_decoder

Overview:
- Downstream consumer of the priority encoder.
- Takes the encoder's one-hot left (MSB) and right (LSB) words and converts each to a binary bit index.
- Computes the span between the two indices, flags zero and malformed words, and buffers results in a small FIFO with valid/ready output.
- The upstream encoder has no backpressure, so the FIFO absorbs stalls and accounts for every dropped word.

Parameters:
- WIDTH, 16, width of data_left_i/data_right_i; must be >= 2.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- IDX_W (localparam), $clog2(WIDTH), width of one bit index.
- CNT_W, 16, width of drop counter.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- data_left_i  in  WIDTH  one-hot MSB word from encoder
- data_right_i  in  WIDTH  one-hot LSB word from encoder
- data_val_i  in  1  input qualifier; no ready, always accepted or dropped
- left_idx_o  out  IDX_W  binary index of left bit
- right_idx_o  out  IDX_W  binary index of right bit
- span_o  out  IDX_W+1  left_idx - right_idx + 1
- zero_o  out  1  both inputs were all-zero (source word was 0)
- err_o  out  1  malformed entry
- valid_o  out  1  FIFO head valid
- ready_i  in  1  consumer accepts head
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow_o  out  1  sticky: at least one word dropped
- drop_cnt_o  out  CNT_W  saturating count of dropped words

Behaviour:
- Reset (rst_n_i low, async):
  - Clears the stage-1 valid, FIFO pointers, level, overflow_o and drop_cnt_o.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - Release is sampled synchronously; the first accept is possible on the first edge after release.
- Stage 1 (registered): on an edge with data_val_i=1, capture both words.
  - Convert each to an index using the onehot_to_index sub-module.
  - Compute classification flags.
- Classification, in priority order:
  - Either word has more than one bit set -> err=1, indices=0, span=0.
  - Both words zero -> zero=1, err=0, indices=0, span=0.
  - Exactly one word zero -> err=1, indices=0, span=0.
  - Both one-hot and left_idx < right_idx -> err=1, indices as decoded, span=0.
  - Otherwise err=0, zero=0, span = left_idx - right_idx + 1, computed unsigned in IDX_W+1 bits (max WIDTH).
- Stage 2 (push): on the next edge, the stage-1 entry is written into the FIFO.
- Latency: data_val_i high in cycle c -> entry visible on outputs with valid_o=1 from cycle c+2, if the FIFO is not full.
  - No bypass: an empty FIFO plus a push still takes the full 2 cycles.
- Throughput: one word per cycle; back-to-back valids are fully pipelined.
- Pop: valid_o & ready_i on an edge removes the head. Outputs always show the head entry; they are 0 when empty (valid_o=0).
- Ordering: strict FIFO order. err and zero entries are stored and popped like normal entries.
- Full boundary:
  - Push while full and no pop in the same edge -> word dropped, overflow_o set (sticky), drop_cnt_o +1, saturating at all-ones.
  - Push and pop in the same edge while full -> push accepted, level unchanged, no drop.
- Empty boundary: ready_i while empty is ignored; pointers do not move.
- Pointer wrap: pointers carry one extra bit for full/empty detection and wrap modulo 2*DEPTH.
- level_o: updated on the same edge as push/pop; range 0..DEPTH.

Decomposition:
- Package onehot_span_pkg:
  - Entry struct typedef: left_idx, right_idx, span, zero, err.
  - Function for the span/classification rule, shared by RTL and the bench reference model.
- Sub-module onehot_to_index, instantiated twice. Combinational OR-tree encoder outputting index, zero and multi-hot flags.
- FIFO storage and pointers stay inline in the top module.

Test Plan (WIDTH=16, DEPTH=4):
- Basic span: left=0x0100, right=0x0004, valid one cycle, ready_i=1 -> two cycles later valid_o=1 for one cycle with left_idx=8, right_idx=2, span=7, zero=0, err=0.
- Zero and single-bit words:
  - left=right=0x0000 -> zero_o=1, err_o=0, span=0.
  - left=right=0x8000 -> span=1, indices 15/15.
- Malformed words:
  - left=0x0003, right=0x0001 -> err_o=1, indices 0, span 0.
  - left=0x0002, right=0x0008 -> err_o=1, left_idx=1, right_idx=3, span 0.
- Overflow: ready_i=0, six back-to-back valid words A..F -> level_o=4, overflow_o=1, drop_cnt_o=2. Then ready_i=1 -> A,B,C,D pop in order and valid_o drops after D.
- Full with simultaneous pop and push: FIFO full, ready_i=1 held, continuous valids -> level_o stays 4, drop_cnt_o unchanged, output order matches input order.
- Async reset mid-stream: level_o=3, overflow_o=1, then assert rst_n_i between edges -> valid_o, level_o, overflow_o, drop_cnt_o are 0 before the next edge. After release, a new word appears 2 cycles after its valid.
